tmr_recovery_ctrl: RTL and testbench

Sequencer around the triple-modular-redundancy bus voter. It enables voting, takes the voter's error flag and per-hart error ID, and runs recovery for a single faulty hart: halt all harts, resynchronise the faulty hart's state, resume, re-enable voting. Multi-hart disagreement or a timed-out step latches an uncorrectable fatal condition. Sits beside the voter in the redundant-core cluster; debug requests go to the cores, resync requests go to the state-copy engine.

---
 rtl/tmr_recovery_ctrl.sv | 131 +++++++++++++
 tb/tb_tmr_recovery_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_recovery_ctrl.sv
// Recovery sequencer for the TMR bus voter: halts all harts, resyncs a single
// faulty hart, resumes, and latches a fatal condition on uncorrectable errors.
module tmr_recovery_ctrl #(
  parameter int NHARTS         = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tmr_en_i,
  input  logic                    voter_error_i,
  input  logic [NHARTS-1:0]       voter_error_id_i,
  output logic                    voter_enable_o,
  output logic [NHARTS-1:0]       debug_req_o,
  input  logic [NHARTS-1:0]       core_halted_i,
  output logic                    resync_req_o,
  output logic [NHARTS-1:0]       resync_id_o,
  input  logic                    resync_done_i,
  output logic                    busy_o,
  output logic                    fatal_o,
  output logic                    irq_o,
  input  logic                    clear_i,
  output logic [NHARTS*CNT_W-1:0] err_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    HALT,
    SYNC,
    RESUME,
    FATAL
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t          state;
  state_t          state_n;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            single_err;
  logic            all_halted;
  logic            none_halted;
  logic            inc_cnt;
  logic            waiting;

  assign tmo_hit     = (tmo_cnt == TMO_LAST);
  assign single_err  = ($countones(voter_error_id_i) == 1);
  assign all_halted  = &core_halted_i;
  assign none_halted = ~|core_halted_i;
  assign waiting     = (state == HALT) || (state == SYNC) || (state == RESUME);

  // Exit conditions are tested before the timeout so a same-cycle exit wins.
  always_comb begin
    state_n = state;
    inc_cnt = 1'b0;
    case (state)
      IDLE: begin
        if (tmr_en_i) state_n = ACTIVE;
      end
      ACTIVE: begin
        if (voter_error_i) begin
          if (single_err) begin
            state_n = HALT;
            inc_cnt = 1'b1;
          end else begin
            state_n = FATAL;
          end
        end else if (!tmr_en_i) begin
          state_n = IDLE;
        end
      end
      HALT: begin
        if (all_halted)   state_n = SYNC;
        else if (tmo_hit) state_n = FATAL;
      end
      SYNC: begin
        if (resync_done_i) state_n = RESUME;
        else if (tmo_hit)  state_n = FATAL;
      end
      RESUME: begin
        if (none_halted)  state_n = tmr_en_i ? ACTIVE : IDLE;
        else if (tmo_hit) state_n = FATAL;
      end
      FATAL: begin
        if (clear_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      voter_enable_o <= 1'b0;
      debug_req_o    <= '0;
      resync_req_o   <= 1'b0;
      resync_id_o    <= '0;
      busy_o         <= 1'b0;
      fatal_o        <= 1'b0;
      irq_o          <= 1'b0;
      err_cnt_o      <= '0;
    end else begin
      state          <= state_n;
      tmo_cnt        <= (waiting && (state_n == state)) ? tmo_cnt + 1'b1 : '0;
      voter_enable_o <= (state_n == ACTIVE);
      debug_req_o    <= (state_n inside {HALT, SYNC, FATAL}) ? '1 : '0;
      resync_req_o   <= (state_n == SYNC);
      busy_o         <= (state_n inside {HALT, SYNC, RESUME});
      fatal_o        <= (state_n == FATAL);
      irq_o          <= ((state_n == FATAL) && (state != FATAL)) ||
                        ((state == RESUME) && (state_n inside {ACTIVE, IDLE}));

      if (inc_cnt)
        resync_id_o <= voter_error_id_i;
      else if (state_n inside {IDLE, ACTIVE})
        resync_id_o <= '0;

      for (int i = 0; i < NHARTS; i++) begin
        if (clear_i)
          err_cnt_o[i*CNT_W +: CNT_W] <= '0;
        else if (inc_cnt && voter_error_id_i[i] && !(&err_cnt_o[i*CNT_W +: CNT_W]))
          err_cnt_o[i*CNT_W +: CNT_W] <= err_cnt_o[i*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Directed bench for tmr_recovery_ctrl with a short timeout and 2-bit counters
// so that timeout and counter saturation are reachable quickly.
module tb_tmr_recovery_ctrl;

  localparam int NH  = 3;
  localparam int TMO = 16;
  localparam int CW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            tmr_en;
  logic            voter_error;
  logic [NH-1:0]   voter_error_id;
  logic            voter_enable;
  logic [NH-1:0]   debug_req;
  logic [NH-1:0]   core_halted;
  logic            resync_req;
  logic [NH-1:0]   resync_id;
  logic            resync_done;
  logic            busy;
  logic            fatal;
  logic            irq;
  logic            clear;
  logic [NH*CW-1:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  tmr_recovery_ctrl #(.NHARTS(NH), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .tmr_en_i(tmr_en),
    .voter_error_i(voter_error), .voter_error_id_i(voter_error_id),
    .voter_enable_o(voter_enable), .debug_req_o(debug_req),
    .core_halted_i(core_halted), .resync_req_o(resync_req),
    .resync_id_o(resync_id), .resync_done_i(resync_done),
    .busy_o(busy), .fatal_o(fatal), .irq_o(irq), .clear_i(clear),
    .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_recovery(input logic [NH-1:0] id, input logic keep_en);
    voter_error = 1'b1; voter_error_id = id;
    tick();
    voter_error = 1'b0; voter_error_id = '0; core_halted = '1;
    tick();
    if (!keep_en) tmr_en = 1'b0;
    resync_done = 1'b1;
    tick();
    resync_done = 1'b0; core_halted = '0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tmr_en = 1'b0; voter_error = 1'b0; voter_error_id = '0;
    core_halted = '0; resync_done = 1'b0; clear = 1'b0;
    #12;
    n_checks++;
    if ({voter_enable, debug_req, resync_req, resync_id} !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl_outs: got %b expected 0", {voter_enable, debug_req, resync_req, resync_id});
    end
    n_checks++;
    if ({busy, fatal, irq, err_cnt} !== 9'h000) begin
      n_fail++;
      $display("[TB] FAIL reset_status_outs: got %b expected 0", {busy, fatal, irq, err_cnt});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_activate();
    tmr_en = 1'b1;
    tick();
    n_checks++;
    if ({voter_enable, busy} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL activate_enable_busy: got %b expected 10", {voter_enable, busy});
    end
    n_checks++;
    if (err_cnt !== 6'd0) begin
      n_fail++;
      $display("[TB] FAIL activate_err_cnt: got %b expected 000000", err_cnt);
    end
  endtask

  task automatic test_recovery();
    voter_error = 1'b1; voter_error_id = 3'b010;
    tick();
    voter_error = 1'b0; voter_error_id = '0;
    n_checks++;
    if ({debug_req, voter_enable, busy, resync_req} !== 6'b111010) begin
      n_fail++;
      $display("[TB] FAIL halt_entry: got %b expected 111010", {debug_req, voter_enable, busy, resync_req});
    end
    core_halted = 3'b111;
    tick();
    n_checks++;
    if ({resync_req, resync_id, debug_req} !== 7'b1010111) begin
      n_fail++;
      $display("[TB] FAIL sync_entry: got %b expected 1010111", {resync_req, resync_id, debug_req});
    end
    resync_done = 1'b1;
    tick();
    resync_done = 1'b0;
    n_checks++;
    if ({resync_req, debug_req, busy, irq} !== 6'b000010) begin
      n_fail++;
      $display("[TB] FAIL resume_entry: got %b expected 000010", {resync_req, debug_req, busy, irq});
    end
    core_halted = 3'b000;
    tick();
    n_checks++;
    if ({irq, voter_enable, busy, resync_id} !== 6'b110000) begin
      n_fail++;
      $display("[TB] FAIL resume_exit: got %b expected 110000", {irq, voter_enable, busy, resync_id});
    end
    n_checks++;
    if (err_cnt !== 6'b00_01_00) begin
      n_fail++;
      $display("[TB] FAIL recovery_err_cnt: got %b expected 000100", err_cnt);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL irq_single_pulse: got %b expected 0", irq);
    end
  endtask

  task automatic test_fatal_multi();
    voter_error = 1'b1; voter_error_id = 3'b011;
    tick();
    voter_error = 1'b0; voter_error_id = '0;
    n_checks++;
    if ({fatal, irq, debug_req, voter_enable, resync_req} !== 7'b1111100) begin
      n_fail++;
      $display("[TB] FAIL fatal_entry: got %b expected 1111100", {fatal, irq, debug_req, voter_enable, resync_req});
    end
    tick();
    n_checks++;
    if ({fatal, irq} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL fatal_hold: got %b expected 10", {fatal, irq});
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if ({fatal, debug_req, voter_enable, err_cnt} !== 11'd0) begin
      n_fail++;
      $display("[TB] FAIL fatal_clear: got %b expected 0", {fatal, debug_req, voter_enable, err_cnt});
    end
    tick();
    n_checks++;
    if (voter_enable !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reenable_after_clear: got %b expected 1", voter_enable);
    end
  endtask

  task automatic test_timeout();
    // Error also wins over a simultaneous tmr_en drop.
    voter_error = 1'b1; voter_error_id = 3'b001; tmr_en = 1'b0;
    tick();
    voter_error = 1'b0; voter_error_id = '0; core_halted = 3'b110;
    for (int i = 0; i < TMO - 1; i++) tick();
    n_checks++;
    if ({fatal, busy, debug_req} !== 5'b01111) begin
      n_fail++;
      $display("[TB] FAIL timeout_not_yet: got %b expected 01111", {fatal, busy, debug_req});
    end
    tick();
    n_checks++;
    if ({fatal, irq, busy} !== 3'b110) begin
      n_fail++;
      $display("[TB] FAIL timeout_fatal: got %b expected 110", {fatal, irq, busy});
    end
    clear = 1'b1;
    tick();
    clear = 1'b0; core_halted = '0; tmr_en = 1'b1;
    tick();
    voter_error = 1'b1; voter_error_id = 3'b001;
    tick();
    voter_error = 1'b0; voter_error_id = '0; core_halted = 3'b110;
    for (int i = 0; i < TMO - 1; i++) tick();
    core_halted = 3'b111;
    tick();
    n_checks++;
    if ({resync_req, fatal, resync_id} !== 5'b10001) begin
      n_fail++;
      $display("[TB] FAIL timeout_exit_wins: got %b expected 10001", {resync_req, fatal, resync_id});
    end
    resync_done = 1'b1;
    tick();
    resync_done = 1'b0; core_halted = '0;
    tick();
    n_checks++;
    if ({voter_enable, irq, err_cnt} !== 8'b11_000001) begin
      n_fail++;
      $display("[TB] FAIL timeout_recovered: got %b expected 11000001", {voter_enable, irq, err_cnt});
    end
  endtask

  task automatic test_clear_active();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if ({voter_enable, err_cnt} !== 7'b1_000000) begin
      n_fail++;
      $display("[TB] FAIL clear_in_active: got %b expected 1000000", {voter_enable, err_cnt});
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) do_recovery(3'b100, 1'b1);
    n_checks++;
    if (err_cnt !== 6'b11_00_00) begin
      n_fail++;
      $display("[TB] FAIL cnt_reach_max: got %b expected 110000", err_cnt);
    end
    do_recovery(3'b100, 1'b0);
    n_checks++;
    if ({err_cnt, voter_enable, irq} !== 8'b110000_01) begin
      n_fail++;
      $display("[TB] FAIL cnt_saturate_idle: got %b expected 11000001", {err_cnt, voter_enable, irq});
    end
    voter_error = 1'b1; voter_error_id = 3'b011;
    tick();
    voter_error = 1'b0; voter_error_id = '0;
    n_checks++;
    if ({fatal, voter_enable, busy} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL error_ignored_idle: got %b expected 000", {fatal, voter_enable, busy});
    end
  endtask

  task automatic test_async_reset();
    tmr_en = 1'b1;
    tick();
    voter_error = 1'b1; voter_error_id = 3'b100;
    tick();
    voter_error = 1'b0; voter_error_id = '0; core_halted = '1;
    tick();
    n_checks++;
    if ({resync_req, debug_req} !== 4'b1111) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_sync: got %b expected 1111", {resync_req, debug_req});
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({resync_req, debug_req, busy, err_cnt} !== 11'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset_drop: got %b expected 0", {resync_req, debug_req, busy, err_cnt});
    end
    tmr_en = 1'b0; core_halted = '0;
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({voter_enable, busy, fatal} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: got %b expected 000", {voter_enable, busy, fatal});
    end
  endtask

  initial begin
    test_reset();
    test_activate();
    test_recovery();
    test_fatal_multi();
    test_timeout();
    test_clear_active();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
